sram_controller: RTL and testbench

Memory-side responder for the pipeline's data-memory stall handshake. Accepts one 32-bit read or write from the MEM stage, performs it as two 16-bit accesses on an external asynchronous SRAM, and holds `ready` low until the transaction completes. The pipeline registers freeze on `!ready`, so the whole pipeline stalls for the duration of each access.

---
 rtl/sram_controller.sv | 119 +++++++++++
 tb/tb_sram_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module  : sram_controller
// Brief   : 32-bit MEM-stage request to two 16-bit async SRAM accesses; ready
//           stays low until the transaction completes.
// Revision: 1.0 - initial release
// ============================================================================
module sram_controller #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic        rdEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] C_WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [17:0] addr_q, addr_d;

  logic        w_drive;
  logic [15:0] w_dq_out;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{address[31:19], address[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      word_q  <= 17'd0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      addr_q  <= 18'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (wrEn || rdEn) begin
          word_d  = address[18:2];
          wdata_d = writeData;
          wr_d    = wrEn;
          addr_d  = {address[18:2], 1'b0};
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (!wr_q) rdata_d[15:0] = SRAM_DQ;
        addr_d  = {word_q, 1'b1};
        state_d = S_HI;
      end
      S_HI: begin
        if (!wr_q) rdata_d[31:16] = SRAM_DQ;
        cnt_d   = 4'd0;
        state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == C_WAIT_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Gating with rst keeps the bus released while reset is held mid-write.
  assign w_drive   = wr_q && ((state_q == S_LO) || (state_q == S_HI)) && !rst;
  assign w_dq_out  = (state_q == S_HI) ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ   = w_drive ? w_dq_out : 16'hzzzz;
  assign SRAM_WE_N = !w_drive;
  assign SRAM_ADDR = addr_q;
  assign readData  = rdata_q;
  assign ready     = (state_q == S_DONE) || ((state_q == S_IDLE) && !wrEn && !rdEn);

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_controller
// Brief   : Self-checking bench for sram_controller with behavioural SRAMs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrEn, rdEn;
  logic [31:0] address, writeData;
  logic [31:0] readData, readData0;
  logic        ready, ready0;
  wire  [15:0] dq, dq0;
  logic [17:0] sa, sa0;
  logic        we_n, we_n0;

  logic [15:0] mem  [0:255];
  logic [15:0] mem0 [0:255];
  logic [31:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_controller u_dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .rdEn(rdEn), .address(address),
    .writeData(writeData), .readData(readData), .ready(ready),
    .SRAM_DQ(dq), .SRAM_ADDR(sa), .SRAM_WE_N(we_n)
  );

  sram_controller #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .wrEn(wrEn), .rdEn(rdEn), .address(address),
    .writeData(writeData), .readData(readData0), .ready(ready0),
    .SRAM_DQ(dq0), .SRAM_ADDR(sa0), .SRAM_WE_N(we_n0)
  );

  // SRAM models: output enabled whenever not writing
  assign dq  = we_n  ? mem[sa[7:0]]   : 16'hzzzz;
  assign dq0 = we_n0 ? mem0[sa0[7:0]] : 16'hzzzz;
  always @(posedge clk) if (!we_n)  mem[sa[7:0]]   <= dq;
  always @(posedge clk) if (!we_n0) mem0[sa0[7:0]] <= dq0;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      wrEn = 1'b0; rdEn = 1'b0;
    end
  endtask

  // Runs one transaction; returns cycle of first ready, WE_N-low cycle mask, readData at DONE
  task automatic txn(input bit sel, input logic we, input logic re, input logic [31:0] a,
                     input logic [31:0] d, input int drop_at, input bit scr,
                     output int rdy_cyc, output int we_mask, output logic [31:0] rd_done);
    rdy_cyc = -1; we_mask = 0; rd_done = 32'd0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        wrEn = we; rdEn = re; address = a; writeData = d;
      end else if (scr && c == 1) begin
        address = ~a; writeData = ~d;
      end
      if (c == drop_at) begin
        wrEn = 1'b0; rdEn = 1'b0;
      end
      #1;
      if ((sel ? we_n0 : we_n) == 1'b0) we_mask |= (1 << c);
      if ((sel ? ready0 : ready) === 1'b1) begin
        rdy_cyc = c;
        rd_done = sel ? readData0 : readData;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0; address = 32'd0; writeData = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready cyc %0d: got %b want 1", i, ready); end
      n_checks++;
      if (readData !== 32'd0) begin n_fail++; $display("FAIL reset_rdata cyc %0d: got %h want 0", i, readData); end
      n_checks++;
      if (we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n cyc %0d: got %b want 1", i, we_n); end
      n_checks++;
      if (dq !== mem[sa[7:0]]) begin n_fail++; $display("FAIL reset_dq_released cyc %0d: got %h want %h", i, dq, mem[sa[7:0]]); end
    end
    n_checks++;
    if (sa !== 18'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", sa); end
  endtask

  task automatic test_write;
    int r, m; logic [31:0] rd;
    txn(1'b0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, -1, 1'b1, r, m, rd);
    idle(1);
    n_checks++;
    if (r !== 6) begin n_fail++; $display("FAIL write_latency: got %0d want 6", r); end
    n_checks++;
    if (m !== 6) begin n_fail++; $display("FAIL write_we_mask: got %0h want 6", m); end
    n_checks++;
    if (mem[8'h20] !== 16'hBEEF) begin n_fail++; $display("FAIL write_lo: got %h want BEEF", mem[8'h20]); end
    n_checks++;
    if (mem[8'h21] !== 16'hDEAD) begin n_fail++; $display("FAIL write_hi: got %h want DEAD", mem[8'h21]); end
    n_checks++;
    if (readData !== 32'd0) begin n_fail++; $display("FAIL write_keeps_rdata: got %h want 0", readData); end
    idle(9);
  endtask

  task automatic test_read;
    int r, m; logic [31:0] rd, e;
    exp_q.push_back(32'hDEADBEEF);
    txn(1'b0, 1'b0, 1'b1, 32'h43, 32'h0, -1, 1'b1, r, m, rd);
    e = exp_q.pop_front();
    n_checks++;
    if (r !== 6) begin n_fail++; $display("FAIL read_latency: got %0d want 6", r); end
    n_checks++;
    if (m !== 0) begin n_fail++; $display("FAIL read_we_mask: got %0h want 0", m); end
    n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL read_data_done: got %h want %h", rd, e); end
    for (int i = 0; i < 3; i++) begin
      idle(1); #1;
      n_checks++;
      if (readData !== e) begin n_fail++; $display("FAIL read_data_hold cyc %0d: got %h want %h", i, readData, e); end
    end
    idle(5);
  endtask

  task automatic test_back_to_back;
    int r1, r2, m1, m2; logic [31:0] rd, e;
    txn(1'b0, 1'b1, 1'b0, 32'h8, 32'h11223344, -1, 1'b0, r1, m1, rd);
    exp_q.push_back(32'h11223344);
    txn(1'b0, 1'b0, 1'b1, 32'h8, 32'h0, -1, 1'b0, r2, m2, rd);
    e = exp_q.pop_front();
    idle(1);
    n_checks++;
    if (r1 !== 6) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 6", r1); end
    n_checks++;
    if (r2 !== 6) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 6", r2); end
    n_checks++;
    if (m1 !== 6) begin n_fail++; $display("FAIL b2b_write_we_mask: got %0h want 6", m1); end
    n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL b2b_read_data: got %h want %h", rd, e); end
    idle(9);
  endtask

  task automatic test_both;
    int r, m; logic [31:0] rd;
    txn(1'b0, 1'b1, 1'b1, 32'hC, 32'hA5A5A5A5, 2, 1'b0, r, m, rd);
    idle(1);
    n_checks++;
    if (r !== 6) begin n_fail++; $display("FAIL both_latency_dropped: got %0d want 6", r); end
    n_checks++;
    if (m !== 6) begin n_fail++; $display("FAIL both_we_mask: got %0h want 6", m); end
    n_checks++;
    if (mem[8'h06] !== 16'hA5A5 || mem[8'h07] !== 16'hA5A5) begin
      n_fail++; $display("FAIL both_write_mem: got %h_%h want A5A5_A5A5", mem[8'h07], mem[8'h06]);
    end
    n_checks++;
    if (readData !== 32'h11223344) begin n_fail++; $display("FAIL both_rdata_kept: got %h want 11223344", readData); end
    idle(9);
  endtask

  task automatic test_rst_wait;
    int r, m; logic [31:0] rd, e;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin rdEn = 1'b1; address = 32'h40; end
      if (c == 4) begin rst = 1'b1; rdEn = 1'b0; end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_wait_ready: got %b want 1", ready); end
    n_checks++;
    if (readData !== 32'd0) begin n_fail++; $display("FAIL rst_wait_rdata: got %h want 0", readData); end
    n_checks++;
    if (we_n !== 1'b1) begin n_fail++; $display("FAIL rst_wait_we_n: got %b want 1", we_n); end
    n_checks++;
    if (dq !== mem[sa[7:0]]) begin n_fail++; $display("FAIL rst_wait_dq_released: got %h want %h", dq, mem[sa[7:0]]); end
    n_checks++;
    if (sa !== 18'd0) begin n_fail++; $display("FAIL rst_wait_addr: got %h want 0", sa); end
    exp_q.push_back(32'hDEADBEEF);
    txn(1'b0, 1'b0, 1'b1, 32'h40, 32'h0, -1, 1'b0, r, m, rd);
    e = exp_q.pop_front();
    idle(1);
    n_checks++;
    if (r !== 6) begin n_fail++; $display("FAIL rst_wait_next_latency: got %0d want 6", r); end
    n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL rst_wait_next_data: got %h want %h", rd, e); end
    idle(9);
  endtask

  task automatic test_wait0;
    int r, m; logic [31:0] rd, e;
    txn(1'b1, 1'b1, 1'b0, 32'h10, 32'h12345678, -1, 1'b0, r, m, rd);
    idle(1);
    n_checks++;
    if (r !== 3) begin n_fail++; $display("FAIL w0_write_latency: got %0d want 3", r); end
    n_checks++;
    if (m !== 6) begin n_fail++; $display("FAIL w0_we_mask: got %0h want 6", m); end
    n_checks++;
    if (mem0[8'h08] !== 16'h5678 || mem0[8'h09] !== 16'h1234) begin
      n_fail++; $display("FAIL w0_write_mem: got %h_%h want 1234_5678", mem0[8'h09], mem0[8'h08]);
    end
    idle(9);
    // Reset during HI of the zero-wait instance
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin rdEn = 1'b1; address = 32'h10; end
      if (c == 2) begin rst = 1'b1; rdEn = 1'b0; end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (ready0 !== 1'b1 || we_n0 !== 1'b1 || readData0 !== 32'd0) begin
      n_fail++; $display("FAIL w0_rst: got ready=%b we_n=%b rdata=%h want 1 1 0", ready0, we_n0, readData0);
    end
    exp_q.push_back(32'h12345678);
    txn(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, -1, 1'b0, r, m, rd);
    e = exp_q.pop_front();
    idle(1);
    n_checks++;
    if (r !== 3) begin n_fail++; $display("FAIL w0_read_latency: got %0d want 3", r); end
    n_checks++;
    if (rd !== e) begin n_fail++; $display("FAIL w0_read_data: got %h want %h", rd, e); end
    idle(9);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 16'hA000 | 16'(i);
      mem0[i] = 16'hB000 | 16'(i);
    end
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_both();
    test_rst_wait();
    test_wait0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
